// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logical/compare unit: the operation
// codes for both decodes and a default-width result record.
package logic_unit_pkg;

  // Non-branch (logical / set / min-max) decode of funct
  localparam logic [3:0] FN_SLT  = 4'b0010;
  localparam logic [3:0] FN_SLTU = 4'b0011;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0110;
  localparam logic [3:0] FN_AND  = 4'b0111;
  localparam logic [3:0] FN_MIN  = 4'b1000;
  localparam logic [3:0] FN_MAX  = 4'b1001;
  localparam logic [3:0] FN_MINU = 4'b1010;
  localparam logic [3:0] FN_MAXU = 4'b1011;
  localparam logic [3:0] FN_XNOR = 4'b1100;
  localparam logic [3:0] FN_ORN  = 4'b1110;
  localparam logic [3:0] FN_ANDN = 4'b1111;

  // Branch-compare decode of funct (funct[3]=1 never matches, so never taken)
  localparam logic [3:0] BR_EQ  = 4'b0000;
  localparam logic [3:0] BR_NE  = 4'b0001;
  localparam logic [3:0] BR_LT  = 4'b0100;
  localparam logic [3:0] BR_GE  = 4'b0101;
  localparam logic [3:0] BR_LTU = 4'b0110;
  localparam logic [3:0] BR_GEU = 4'b0111;

  // Default widths of the result record; the pipe builds its own copy from
  // its XLEN/TAG_W parameters with the same field order.
  localparam int LU_XLEN  = 32;
  localparam int LU_TAG_W = 5;

  typedef struct packed {
    logic [LU_XLEN-1:0]  res;
    logic                taken;
    logic [LU_TAG_W-1:0] tag;
  } lu_result_t;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational decode/compute of one logical or branch-compare op.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      funct_i,
  input  logic            is_branch_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] res_o,
  output logic            taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (op1_i == op2_i);
  assign lt_s = ($signed(op1_i) < $signed(op2_i));
  assign lt_u = (op1_i < op2_i);

  // Branch ops only drive taken, logical ops only drive res; the other is 0
  always_comb begin
    res_o   = '0;
    taken_o = 1'b0;
    if (is_branch_i) begin
      case (funct_i)
        BR_EQ:   taken_o = eq;
        BR_NE:   taken_o = !eq;
        BR_LT:   taken_o = lt_s;
        BR_GE:   taken_o = !lt_s;
        BR_LTU:  taken_o = lt_u;
        BR_GEU:  taken_o = !lt_u;
        default: taken_o = 1'b0;
      endcase
    end else begin
      case (funct_i)
        FN_SLT:  res_o = {{(XLEN-1){1'b0}}, lt_s};
        FN_SLTU: res_o = {{(XLEN-1){1'b0}}, lt_u};
        FN_XOR:  res_o = op1_i ^ op2_i;
        FN_OR:   res_o = op1_i | op2_i;
        FN_AND:  res_o = op1_i & op2_i;
        FN_MIN:  res_o = lt_s ? op1_i : op2_i;
        FN_MAX:  res_o = lt_s ? op2_i : op1_i;
        FN_MINU: res_o = lt_u ? op1_i : op2_i;
        FN_MAXU: res_o = lt_u ? op2_i : op1_i;
        FN_XNOR: res_o = ~(op1_i ^ op2_i);
        FN_ORN:  res_o = op1_i | ~op2_i;
        FN_ANDN: res_o = op1_i & ~op2_i;
        default: res_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logical/compare unit: valid/ready stages around logic_unit_core,
// one (LATENCY=1) or two (LATENCY=2) register stages deep.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once out_valid_o is high its payload holds until out_ready_i takes
// it. in_ready_o depends on out_ready_i but never on in_valid_i. flush_i
// clears every valid bit on its edge and discards any op offered then.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       funct_i,
  input  logic             is_branch_op_i,
  input  logic [XLEN-1:0]  op1_i,
  input  logic [XLEN-1:0]  op2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic             branch_taken_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic             taken;
    logic [TAG_W-1:0] tag;
  } result_t;

  typedef struct packed {
    logic [3:0]       funct;
    logic             is_branch;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [TAG_W-1:0] tag;
  } operand_t;

  // Core inputs come from the ports (LATENCY=1) or from stage 0 (LATENCY=2)
  logic [3:0]       core_funct;
  logic             core_is_branch;
  logic [XLEN-1:0]  core_op1;
  logic [XLEN-1:0]  core_op2;
  logic [TAG_W-1:0] core_tag;
  logic [XLEN-1:0]  core_res;
  logic             core_taken;

  // Output stage, common to both latencies
  result_t out_q;
  result_t out_d;
  logic    out_valid_q;
  logic    accept;

  logic_unit_core #(.XLEN(XLEN)) u_core (
    .funct_i     (core_funct),
    .is_branch_i (core_is_branch),
    .op1_i       (core_op1),
    .op2_i       (core_op2),
    .res_o       (core_res),
    .taken_o     (core_taken)
  );

  assign out_d  = {core_res, core_taken, core_tag};
  assign accept = in_valid_i & in_ready_o & !flush_i;

  // Any LATENCY other than 1 builds the two-stage pipe
  if (LATENCY == 1) begin : g_lat1
    assign core_funct     = funct_i;
    assign core_is_branch = is_branch_op_i;
    assign core_op1       = op1_i;
    assign core_op2       = op2_i;
    assign core_tag       = tag_i;
    assign in_ready_o     = !out_valid_q | out_ready_i;

    // Single stage: compute on the accept edge, hold while stalled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end else begin
        if (flush_i) begin
          out_valid_q <= 1'b0;
        end else if (in_ready_o) begin
          out_valid_q <= in_valid_i;
        end
        if (accept) begin
          out_q <= out_d;
        end
      end
    end
  end else begin : g_lat2
    operand_t s0_q;
    logic     s0_valid_q;
    logic     s1_load;
    logic     s0_adv;

    assign core_funct     = s0_q.funct;
    assign core_is_branch = s0_q.is_branch;
    assign core_op1       = s0_q.op1;
    assign core_op2       = s0_q.op2;
    assign core_tag       = s0_q.tag;

    // Stage 1 loads when empty or being drained this edge (bubbles collapse)
    assign s1_load    = !out_valid_q | out_ready_i;
    assign s0_adv     = s0_valid_q & s1_load;
    assign in_ready_o = !s0_valid_q | s0_adv;

    // Stage 0 registers operands, stage 1 registers the computed result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s0_valid_q  <= 1'b0;
        s0_q        <= '0;
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end else begin
        if (flush_i) begin
          s0_valid_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end else begin
          if (s1_load) begin
            out_valid_q <= s0_valid_q;
          end
          if (in_ready_o) begin
            s0_valid_q <= in_valid_i;
          end
        end
        if (s0_adv) begin
          out_q <= out_d;
        end
        if (accept) begin
          s0_q <= {funct_i, is_branch_op_i, op1_i, op2_i, tag_i};
        end
      end
    end
  end

  assign out_valid_o    = out_valid_q;
  assign res_o          = out_q.res;
  assign branch_taken_o = out_q.taken;
  assign tag_o          = out_q.tag;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: four instances (XLEN 32/64 x LATENCY 1/2), one
// selected at a time; a shared driver, scoreboard and monitor.
module tb_logic_unit_pipe;

  localparam int TAG_W = 5;
  localparam int EW    = 64 + 1 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [3:0]       funct;
  logic             is_branch;
  logic [63:0]      op1;
  logic [63:0]      op2;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] next_tag;
  int               sel;
  int               ready_mode;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  function automatic int cfg_xlen(input int s);
    return (s >= 2) ? 64 : 32;
  endfunction

  function automatic int cfg_lat(input int s);
    return (s % 2 == 0) ? 1 : 2;
  endfunction

  // ---------------- DUT instances ----------------
  logic iv0, iv1, iv2, iv3, or0, or1, or2, or3;
  logic ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3, tk0, tk1, tk2, tk3;
  logic [31:0] res0, res1;
  logic [63:0] res2, res3;
  logic [TAG_W-1:0] tag0, tag1, tag2, tag3;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);
  assign iv3 = in_valid && (sel == 3);
  assign or0 = out_ready && (sel == 0);
  assign or1 = out_ready && (sel == 1);
  assign or2 = out_ready && (sel == 2);
  assign or3 = out_ready && (sel == 3);

  logic_unit_pipe #(.XLEN(32), .LATENCY(1), .TAG_W(TAG_W)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(iv0), .in_ready_o(ir0),
    .funct_i(funct), .is_branch_op_i(is_branch), .op1_i(op1[31:0]), .op2_i(op2[31:0]),
    .tag_i(tag_in), .out_valid_o(ov0), .out_ready_i(or0), .res_o(res0),
    .branch_taken_o(tk0), .tag_o(tag0));

  logic_unit_pipe #(.XLEN(32), .LATENCY(2), .TAG_W(TAG_W)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(iv1), .in_ready_o(ir1),
    .funct_i(funct), .is_branch_op_i(is_branch), .op1_i(op1[31:0]), .op2_i(op2[31:0]),
    .tag_i(tag_in), .out_valid_o(ov1), .out_ready_i(or1), .res_o(res1),
    .branch_taken_o(tk1), .tag_o(tag1));

  logic_unit_pipe #(.XLEN(64), .LATENCY(1), .TAG_W(TAG_W)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(iv2), .in_ready_o(ir2),
    .funct_i(funct), .is_branch_op_i(is_branch), .op1_i(op1), .op2_i(op2),
    .tag_i(tag_in), .out_valid_o(ov2), .out_ready_i(or2), .res_o(res2),
    .branch_taken_o(tk2), .tag_o(tag2));

  logic_unit_pipe #(.XLEN(64), .LATENCY(2), .TAG_W(TAG_W)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(iv3), .in_ready_o(ir3),
    .funct_i(funct), .is_branch_op_i(is_branch), .op1_i(op1), .op2_i(op2),
    .tag_i(tag_in), .out_valid_o(ov3), .out_ready_i(or3), .res_o(res3),
    .branch_taken_o(tk3), .tag_o(tag3));

  // Outputs of the selected instance
  logic             m_ov, m_ir, m_tk;
  logic [63:0]      m_res;
  logic [TAG_W-1:0] m_tag;

  always_comb begin
    m_ov = 1'b0; m_ir = 1'b0; m_tk = 1'b0; m_res = '0; m_tag = '0;
    case (sel)
      0: begin m_ov = ov0; m_ir = ir0; m_tk = tk0; m_res = {32'h0, res0}; m_tag = tag0; end
      1: begin m_ov = ov1; m_ir = ir1; m_tk = tk1; m_res = {32'h0, res1}; m_tag = tag1; end
      2: begin m_ov = ov2; m_ir = ir2; m_tk = tk2; m_res = res2; m_tag = tag2; end
      3: begin m_ov = ov3; m_ir = ir3; m_tk = tk3; m_res = res3; m_tag = tag3; end
      default: ;
    endcase
  end

  // ---------------- reference model ----------------
  // Operation semantics as integer arithmetic on XLEN-bit values.
  function automatic logic [EW-1:0] model(input logic [3:0] f, input logic br,
                                          input logic [63:0] a_in, input logic [63:0] b_in,
                                          input int xl, input logic [TAG_W-1:0] t);
    logic [63:0] mask, a, b, r;
    longint      sa, sb;
    logic        tk, lts, ltu;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = (xl == 64) ? longint'(a) : longint'(int'(a[31:0]));
    sb   = (xl == 64) ? longint'(b) : longint'(int'(b[31:0]));
    lts  = (sa < sb);
    ltu  = (a < b);
    r    = 64'd0;
    tk   = 1'b0;
    if (br) begin
      case (f)
        4'd0: tk = (a == b);
        4'd1: tk = (a != b);
        4'd4: tk = lts;
        4'd5: tk = !lts;
        4'd6: tk = ltu;
        4'd7: tk = !ltu;
        default: tk = 1'b0;
      endcase
    end else begin
      case (f)
        4'd2:  r = lts ? 64'd1 : 64'd0;
        4'd3:  r = ltu ? 64'd1 : 64'd0;
        4'd4:  r = a ^ b;
        4'd6:  r = a | b;
        4'd7:  r = a & b;
        4'd8:  r = lts ? a : b;
        4'd9:  r = lts ? b : a;
        4'd10: r = ltu ? a : b;
        4'd11: r = ltu ? b : a;
        4'd12: r = ~(a ^ b);
        4'd14: r = a | ~b;
        4'd15: r = a & ~b;
        default: r = 64'd0;
      endcase
    end
    r = r & mask;
    return {r, tk, t};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s sel=%0d actual=%0h required=%0h", name, sel, act, req);
    end
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    if (mode == 0) out_ready = 1'b1;
    else if (mode == 2) out_ready = 1'b0;
  endtask

  // Background consumer: always ready, random, or stalled
  initial begin : consumer
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver ----------------
  // Offers one op and returns #1 after the edge that accepted it (in_valid
  // stays high so consecutive calls are back-to-back).
  task automatic issue(input logic [3:0] f, input logic b, input logic [63:0] x, input logic [63:0] y);
    int waited;
    funct = f; is_branch = b; op1 = x; op2 = y; tag_in = next_tag; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (m_ir) begin
        exp_q.push_back(model(f, b, x, y, cfg_xlen(sel), tag_in));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        checks++; failures++;
        $display("FAIL issue_timeout sel=%0d actual=in_ready_low required=accept", sel);
        break;
      end
    end
    next_tag = next_tag + 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int c;
    in_valid = 1'b0;
    c = 0;
    while ((exp_q.size() != 0 || m_ov) && c < 500) begin
      @(posedge clk); #1; c++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] pick(input int xl);
    logic [63:0] msb;
    msb = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return msb;
      3: return msb - 64'd1;
      4: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic             hold_v;
    logic [63:0]      hold_res;
    logic             hold_tk;
    logic [TAG_W-1:0] hold_tag;
    logic [EW-1:0]    exp;
    hold_v = 1'b0; hold_res = '0; hold_tk = 1'b0; hold_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          checks++;
          if (!(m_ov && m_res == hold_res && m_tk == hold_tk && m_tag == hold_tag)) begin
            failures++;
            $display("FAIL stall_hold sel=%0d actual=%0b/%0h/%0b/%0h required=1/%0h/%0b/%0h",
                     sel, m_ov, m_res, m_tk, m_tag, hold_res, hold_tk, hold_tag);
          end
        end
        if (m_ov && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output sel=%0d actual=%0h/%0b/%0h required=none",
                     sel, m_res, m_tk, m_tag);
          end else begin
            exp = exp_q.pop_front();
            if ({m_res, m_tk, m_tag} !== exp) begin
              failures++;
              $display("FAIL result sel=%0d actual=%0h/%0b/%0h required=%0h/%0b/%0h",
                       sel, m_res, m_tk, m_tag, exp[EW-1:TAG_W+1], exp[TAG_W], exp[TAG_W-1:0]);
            end
          end
        end
        hold_v   = m_ov && !out_ready;
        hold_res = m_res; hold_tk = m_tk; hold_tag = m_tag;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [63:0] msb, ones;
    logic [63:0] bp_a [3];
    int n, lat;
    time t0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ready_mode = 0;
    funct = '0; is_branch = 1'b0; op1 = '0; op2 = '0; tag_in = '0; next_tag = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state of every instance
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      check("reset_out_valid", 64'(m_ov), 64'd0);
      check("reset_in_ready", 64'(m_ir), 64'd1);
      check("reset_res", m_res, 64'd0);
      check("reset_taken", 64'(m_tk), 64'd0);
      check("reset_tag", 64'(m_tag), 64'd0);
    end
    sel = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      sel  = s;
      msb  = (cfg_xlen(s) == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      ones = 64'hFFFF_FFFF_FFFF_FFFF;
      idle_cycles(2);

      // Latency of a lone op
      set_ready(0);
      issue(4'b0010, 1'b0, ones, 64'd1);
      in_valid = 1'b0;
      lat = 1;
      while (!m_ov && lat < 6) begin @(posedge clk); #1; lat++; end
      check("latency", 64'(lat), 64'(cfg_lat(s)));
      wait_drain();

      // Directed vectors, back-to-back at full throughput
      t0 = $time;
      issue(4'b0010, 1'b0, ones, 64'd1);                       // SLT
      issue(4'b0011, 1'b0, ones, 64'd1);                       // SLTU
      issue(4'b1000, 1'b0, msb, msb - 64'd1);                  // MIN
      issue(4'b1011, 1'b0, msb, msb - 64'd1);                  // MAXU
      issue(4'b1010, 1'b0, msb, msb - 64'd1);                  // MINU
      issue(4'b1111, 1'b0, 64'hF0F0_F0F0, 64'hFF00_FF00);      // ANDN
      issue(4'b0000, 1'b1, 64'h1234, 64'h1234);                // EQ
      issue(4'b0001, 1'b1, 64'h1234, 64'h1234);                // NE
      check("throughput_cycles", 64'(($time - t0) / 10), 64'd8);
      issue(4'b0111, 1'b1, 64'd0, ones);                       // GEU
      issue(4'b1000, 1'b1, 64'd5, 64'd9);                      // branch funct[3]=1
      issue(4'b0100, 1'b1, msb, msb - 64'd1);                  // LT boundary
      issue(4'b0110, 1'b1, msb, msb - 64'd1);                  // LTU boundary
      issue(4'b1001, 1'b0, msb, msb - 64'd1);                  // MAX
      issue(4'b1100, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000); // XNOR
      issue(4'b1110, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000); // ORN
      issue(4'b0101, 1'b0, 64'd7, 64'd3);                      // unlisted code
      wait_drain();

      // Back-pressure: with the consumer stalled only LATENCY ops fit
      set_ready(2);
      @(posedge clk); #1;
      bp_a[0] = 64'h11; bp_a[1] = 64'h22; bp_a[2] = 64'h33;
      n = 0;
      funct = 4'b0110; is_branch = 1'b0; op1 = bp_a[0]; op2 = 64'h100; tag_in = next_tag;
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (m_ir && n < 3) begin
          exp_q.push_back(model(funct, is_branch, op1, op2, cfg_xlen(s), tag_in));
          n++;
          next_tag = next_tag + 1'b1;
        end
        @(posedge clk); #1;
        if (n < 3) begin op1 = bp_a[n]; tag_in = next_tag; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_accepted", 64'(n), 64'(cfg_lat(s)));
      check("bp_in_ready_low", 64'(m_ir), 64'd0);
      check("bp_out_valid", 64'(m_ov), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_ready(0);
      wait_drain();

      // Flush with ops in flight and a new op offered on the flush edge
      set_ready(2);
      @(posedge clk); #1;
      for (int k = 0; k < cfg_lat(s); k++) issue(4'b0100, 1'b0, 64'hAA, 64'h55);
      funct = 4'b0110; is_branch = 1'b0; op1 = 64'hDEAD; op2 = 64'hBEEF; tag_in = next_tag;
      in_valid = 1'b1; flush = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", 64'(m_ov), 64'd0);
      check("flush_in_ready", 64'(m_ir), 64'd1);
      set_ready(0);
      idle_cycles(6);

      // Asynchronous reset between edges with ops in flight
      set_ready(2);
      @(posedge clk); #1;
      for (int k = 0; k < cfg_lat(s); k++) issue(4'b0111, 1'b0, ones, 64'h0F0F);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("async_rst_out_valid", 64'(m_ov), 64'd0);
      check("async_rst_res", m_res, 64'd0);
      check("async_rst_taken", 64'(m_tk), 64'd0);
      check("async_rst_tag", 64'(m_tag), 64'd0);
      check("async_rst_in_ready", 64'(m_ir), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_ready(0);
      issue(4'b0100, 1'b0, 64'h5A5A, 64'h0FF0);
      wait_drain();

      // Random traffic with a randomly stalling consumer
      set_ready(1);
      for (int i = 0; i < 150; i++) begin
        logic [63:0] x;
        x = pick(cfg_xlen(s));
        issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), x,
              ($urandom_range(0, 3) == 0) ? x : pick(cfg_xlen(s)));
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
      end
      set_ready(0);
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Pipelined, parametrised logical/compare execution unit for the integer datapath. It computes the RV32I logical ops and branch comparisons, plus min/max and inverted-logic ops. Each operation carries a tag, flows through a valid/ready handshake with back-pressure and flush, and produces a registered result after a configurable latency. It sits between issue and writeback/branch resolution, replacing the single-cycle combinational logic unit.

## Interface
- XLEN, 32: operand/result width; legal values 32 or 64.
- LATENCY, 1: pipeline stages from accept to result valid; legal values 1 or 2.
- TAG_W, 5: width of the sideband tag, passed through unchanged.
- clk_i  input  1  clock.
- rst_n_i  input  1  reset; asynchronous assert, active-low.
- flush_i  input  1  synchronous kill of all in-flight ops.
- in_valid_i  input  1  operation offered.
- in_ready_o  output  1  unit can accept this cycle.
- funct_i  input  4  operation code (see Operation).
- is_branch_op_i  input  1  1 selects the branch-compare decode of funct_i.
- op1_i, op2_i  input  XLEN  operands.
- tag_i  input  TAG_W  sideband tag.
- out_valid_o  output  1  result presented.
- out_ready_i  input  1  consumer accepts the result.
- res_o  output  XLEN  logical result (0 for branch ops).
- branch_taken_o  output  1  compare outcome (0 for non-branch ops).
- tag_o  output  TAG_W  tag of the presented result.

## Operation
- Non-branch decode:
  - 0010 SLT, 0011 SLTU: result zero-extended to XLEN.
  - 0100 XOR, 0110 OR, 0111 AND.
  - 1000 MIN, 1001 MAX: signed.
  - 1010 MINU, 1011 MAXU: unsigned.
  - 1100 XNOR, 1110 ORN (op1 | ~op2), 1111 ANDN (op1 & ~op2).
  - Any other code: res 0.
- Branch decode:
  - 0000 EQ, 0001 NE, 0100 LT, 0101 GE: LT/GE signed.
  - 0110 LTU, 0111 GEU: unsigned.
  - funct_i[3]=1 or any unlisted code: taken 0.
- Signed compares use full XLEN two's complement. No carry or overflow output. Comparisons are exact at the boundaries: 0x8000_0000 < 0x7FFF_FFFF signed, and > unsigned.
- Each stage holds a valid bit and payload. A stage loads when it is empty or its downstream consumer takes its contents in the same cycle, so bubbles collapse.

## Timing
- Accept on rising edge with in_valid_i & in_ready_o.
- in_ready_o = !stage0_valid | stage0_advances. This is combinational from out_ready_i; there is no combinational path from in_valid_i.
- Latency:
  - LATENCY=1: operands are computed combinationally and registered; out_valid_o rises on the edge that accepts the op.
  - LATENCY=2: operands and tag are registered in stage 0, and the result is computed into stage 1. Result appears one edge later.
- Throughput is 1 op/cycle when out_ready_i is held high.
- Stall: while out_valid_o & !out_ready_i, res_o, branch_taken_o and tag_o hold stable. Upstream stages fill, then in_ready_o drops.
- Flush: on the edge where flush_i=1, every valid bit clears. Any op offered that same cycle is discarded, even if in_ready_o=1. in_ready_o is 1 the following cycle.
- Reset (async, rst_n_i=0): all valid bits, res_o, branch_taken_o and tag_o go to 0; in_ready_o=1. Ops in flight when reset asserts are lost.
- Payload registers clear only on reset. On flush they may hold stale data, but stale data must never be visible while out_valid_o=1.

## Structure
- Package logic_unit_pkg:
  - funct code localparams for both decodes.
  - a packed result struct {res, taken, tag} parametrised through XLEN/TAG_W localparams.
- Sub-module logic_unit_core: purely combinational decode/compute, (funct, is_branch, op1, op2) -> (res, taken). It is instantiated once, in the compute stage.
- logic_unit_pipe wraps the core with the valid/ready stage registers, selected by a generate on LATENCY.

## Test plan
- LATENCY=1, XLEN=32, out_ready held 1: SLT op1=0xFFFF_FFFF, op2=1 -> res 1 next cycle. SLTU with the same operands -> res 0. Back-to-back ops give one result per cycle with tags in order.
- MIN/MAXU: op1=0x8000_0000, op2=0x7FFF_FFFF. MIN -> 0x8000_0000; MAXU -> 0x8000_0000; MINU -> 0x7FFF_FFFF. ANDN op1=0xF0F0_F0F0, op2=0xFF00_FF00 -> 0x00F0_00F0.
- Branches:
  - op1=op2=0x1234: EQ taken=1, NE taken=0, res always 0.
  - GEU with op1=0, op2=0xFFFF_FFFF -> taken 0.
  - funct 1000 with is_branch=1 -> taken 0.
- Back-pressure, LATENCY=2: hold out_ready_i=0 and offer 3 ops.
  - Exactly 2 are accepted, then in_ready_o=0 and the output stays stable.
  - Release out_ready_i: results drain in tag order with no loss or duplication.
- Flush with in_valid_i=1 and 2 ops in flight (LATENCY=2): out_valid_o=0 next cycle, the offered op never appears, and in_ready_o=1.
- Assert rst_n_i mid-stream asynchronously (between edges): all outputs 0 immediately. After release, the first accepted op completes with correct tag. Repeat the full suite with XLEN=64, including the signed boundary 0x8000_0000_0000_0000.
